// File: rtl/vga_fml_text_responder.sv
// vga_fml_text_responder: FML slave serving 4-word text/attribute bursts from on-chip RAM
module vga_fml_text_responder #(
   parameter int ADR_W   = 13,
   parameter int LATENCY = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADR_W:1]   fml_adr_i,
   input  logic             fml_stb_i,
   input  logic             fml_we_i,
   input  logic [1:0]       fml_sel_i,
   input  logic [15:0]      fml_dat_i,
   output logic             fml_ack_o,
   output logic [15:0]      fml_dat_o,
   output logic             busy_o
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACK    = 2'd1;
   localparam logic [1:0] WBURST = 2'd2;
   localparam logic [1:0] RBURST = 2'd3;

   logic [15:0]      ram [0:(1<<ADR_W)-1];
   logic [1:0]       state_q, state_d;
   logic [3:0]       cyc_q, cyc_d;
   logic [ADR_W:3]   base_q, base_d;
   logic             we_q, we_d;
   logic [1:0]       sel_q, sel_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [15:0]      fml_dat_q;
   logic             in_burst;
   logic             wr_en;
   logic             rd_en;
   logic [1:0]       wk;
   logic [1:0]       rk;
   logic             unused_adr;

   assign unused_adr = ^fml_adr_i[2:1];
   assign fml_ack_o  = ack_q;
   assign busy_o     = busy_q;
   assign fml_dat_o  = fml_dat_q;

   // cyc counts cycles since the accept cycle T, so ACK is cycle 1 and beat timing falls out of it
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q + 4'd1;
      base_d  = base_q;
      we_d    = we_q;
      sel_d   = sel_q;
      if (state_q == IDLE) begin
         cyc_d = 4'd1;
         if (fml_stb_i) begin
            state_d = ACK;
            base_d  = fml_adr_i[ADR_W:3];
            we_d    = fml_we_i;
            sel_d   = fml_sel_i;
         end
      end else if (state_q == ACK) begin
         state_d = we_q ? WBURST : RBURST;
      end else if (state_q == WBURST) begin
         state_d = (cyc_q == 4'd4) ? IDLE : WBURST;
      end else begin
         state_d = (cyc_q == 4'(LATENCY + 3)) ? IDLE : RBURST;
      end
      ack_d  = (state_d == ACK);
      busy_d = (state_d != IDLE);
   end

   // beat addressing only touches the two low word bits, so bursts never leave their aligned block
   always_comb begin
      in_burst = (state_q == ACK) || (state_q == WBURST) || (state_q == RBURST);
      wk       = cyc_q[1:0] - 2'd1;
      rk       = cyc_q[1:0] - 2'(LATENCY - 1);
      wr_en    = !rst && in_burst && we_q && (cyc_q >= 4'd1) && (cyc_q <= 4'd4);
      rd_en    = in_burst && !we_q && (cyc_q >= 4'(LATENCY - 1)) && (cyc_q <= 4'(LATENCY + 2));
   end

   // control state; RAM contents are deliberately outside reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cyc_q   <= 4'd0;
         base_q  <= '0;
         we_q    <= 1'b0;
         sel_q   <= 2'b00;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         base_q  <= base_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   // byte-masked write port; a reset cycle drops the beat sampled in it
   always_ff @(posedge clk) begin
      if (wr_en && sel_q[1]) ram[{base_q, wk}][15:8] <= fml_dat_i[15:8];
      if (wr_en && sel_q[0]) ram[{base_q, wk}][7:0]  <= fml_dat_i[7:0];
   end

   // registered read port; output holds the last beat until the next read loads it
   always_ff @(posedge clk) begin
      if (rst) fml_dat_q <= 16'h0000;
      else if (rd_en) fml_dat_q <= ram[{base_q, rk}];
   end
endmodule

// File: tb/tb_vga_fml_text_responder.sv
// tb_vga_fml_text_responder: table-driven bursts with a read-beat scoreboard
module tb_vga_fml_text_responder;
   localparam int LAT = 3;

   typedef struct {
      logic            we;
      logic [12:0]     adr;
      logic [1:0]      sel;
      logic [3:0][15:0] d;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] adr = '0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  sel = 2'b00;
   logic [15:0] dat = '0;
   logic        ack;
   logic [15:0] dout;
   logic        busy;
   int          tests = 0;
   int          fails = 0;
   logic [15:0] q[$];
   vec_t        vecs[12];

   vga_fml_text_responder #(.ADR_W(13), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .fml_adr_i(adr), .fml_stb_i(stb), .fml_we_i(we),
      .fml_sel_i(sel), .fml_dat_i(dat), .fml_ack_o(ack), .fml_dat_o(dout), .busy_o(busy)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic w, logic [12:0] a, logic [1:0] s,
                               logic [15:0] d0, logic [15:0] d1, logic [15:0] d2, logic [15:0] d3);
      vec_t v;
      v.we = w; v.adr = a; v.sel = s;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
      return v;
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pop_chk(string name);
      if (q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: got %h expected <empty scoreboard>", name, dout);
      end else chk(name, dout, q.pop_front());
   endtask

   // one full burst; inputs other than write data are scrambled after T to prove they are latched
   task automatic burst(vec_t v);
      int n;
      @(posedge clk); #1;
      stb = 1'b1; we = v.we; adr = v.adr; sel = v.sel;
      if (!v.we) for (int k = 0; k < 4; k++) q.push_back(v.d[k]);
      @(negedge clk);
      chk("busy_at_T", {15'd0, busy}, 16'd0);
      @(posedge clk); #1;
      stb = 1'b0; adr = ~v.adr; we = ~v.we; sel = ~v.sel; dat = v.d[0];
      @(negedge clk);
      chk("ack_T1", {15'd0, ack}, 16'd1);
      chk("busy_T1", {15'd0, busy}, 16'd1);
      n = v.we ? 4 : LAT + 3;
      for (int c = 2; c <= n; c++) begin
         @(posedge clk); #1;
         if (v.we) dat = v.d[c-1];
         @(negedge clk);
         chk("ack_low", {15'd0, ack}, 16'd0);
         if (!v.we && c >= LAT) pop_chk("rd_beat");
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_end", {15'd0, busy}, 16'd0);
      if (!v.we) chk("dat_hold", dout, v.d[3]);
   endtask

   initial begin
      vecs[0]  = mk(1'b1, 13'h0028, 2'b11, 16'h1741, 16'h1742, 16'h1743, 16'h1744);
      vecs[1]  = mk(1'b0, 13'h002B, 2'b00, 16'h1741, 16'h1742, 16'h1743, 16'h1744);
      vecs[2]  = mk(1'b1, 13'h0030, 2'b11, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
      vecs[3]  = mk(1'b1, 13'h0031, 2'b01, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
      vecs[4]  = mk(1'b0, 13'h0030, 2'b00, 16'hAA34, 16'hAA34, 16'hAA34, 16'hAA34);
      vecs[5]  = mk(1'b1, 13'h0030, 2'b10, 16'h5599, 16'h5599, 16'h5599, 16'h5599);
      vecs[6]  = mk(1'b1, 13'h0032, 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      vecs[7]  = mk(1'b0, 13'h0033, 2'b00, 16'h5534, 16'h5534, 16'h5534, 16'h5534);
      vecs[8]  = mk(1'b1, 13'h1FFF, 2'b11, 16'hBEE0, 16'hBEE1, 16'hBEE2, 16'hBEE3);
      vecs[9]  = mk(1'b1, 13'h0000, 2'b11, 16'h0000, 16'h0001, 16'h0002, 16'h0003);
      vecs[10] = mk(1'b0, 13'h1FFC, 2'b00, 16'hBEE0, 16'hBEE1, 16'hBEE2, 16'hBEE3);
      vecs[11] = mk(1'b0, 13'h0002, 2'b00, 16'h0000, 16'h0001, 16'h0002, 16'h0003);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ack", {15'd0, ack}, 16'd0);
      chk("rst_dat", dout, 16'h0000);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ack", {15'd0, ack}, 16'd0);
      end

      for (int i = 0; i < 12; i++) burst(vecs[i]);

      // stb held high: second accept on the first IDLE cycle, T+7
      @(posedge clk); #1;
      stb = 1'b1; we = 1'b0; adr = 13'h0028;
      for (int r = 0; r < 2; r++) for (int k = 0; k < 4; k++) q.push_back(16'h1741 + 16'(k));
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         if (c == 8) stb = 1'b0;
         @(negedge clk);
         chk("b2b_ack", {15'd0, ack}, {15'd0, (c == 1 || c == 8)});
         if ((c >= 3 && c <= 6) || (c >= 10 && c <= 13)) pop_chk("b2b_beat");
         if (c == 7 || c == 14) chk("b2b_idle", {15'd0, busy}, 16'd0);
      end
      chk("b2b_hold", dout, 16'h1744);

      // reset in the middle of a write: only beat 0 lands
      burst(mk(1'b1, 13'h0040, 2'b11, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3));
      burst(mk(1'b0, 13'h0040, 2'b00, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3));
      @(posedge clk); #1;
      stb = 1'b1; we = 1'b1; adr = 13'h0040; sel = 2'b11;
      @(posedge clk); #1;
      stb = 1'b0; dat = 16'h00C0;
      @(posedge clk); #1;
      dat = 16'h00C1; rst = 1'b1;
      @(posedge clk); #1;
      dat = 16'h00C2; rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", {15'd0, busy}, 16'd0);
      chk("mid_rst_ack", {15'd0, ack}, 16'd0);
      chk("mid_rst_dat", dout, 16'h0000);
      burst(mk(1'b0, 13'h0040, 2'b00, 16'h00C0, 16'h00A1, 16'h00A2, 16'h00A3));

      chk("sb_empty", 16'(q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
